// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache controller and its miss-service
// (block fetch) engine.
//   fetch_state_t   : block-fetch FSM states
//   *_DEF           : default geometry shared with the controller
//   off_w()         : word-offset width for a given block size
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } fetch_state_t;

  localparam int unsigned ADDR_W_DEF    = 15;
  localparam int unsigned WORD_W_DEF    = 32;
  localparam int unsigned BLK_WORDS_DEF = 4;

  // Offset bits needed to select one word inside a block.
  function automatic int unsigned off_w(input int unsigned blk_words);
    return $clog2(blk_words);
  endfunction

endpackage

// File: rtl/cache_block_fetch_timer.sv
// mem_latency_timer: loadable down-counter timing the memory read latency.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   load     : load 'value' into the counter this cycle
//   value    : reload value (MEM_LAT-1 for one memory access)
//   zero     : counter has reached zero
// The counter decrements every cycle it is non-zero and not being loaded,
// and holds at zero.
module mem_latency_timer #(
  parameter int unsigned MEM_LAT = 4,
  localparam int unsigned TW = $clog2(MEM_LAT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          zero
);

  localparam logic [TW-1:0] ONE = TW'(1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  always_comb begin
    zero = (cnt == '0);
  end

endmodule

// File: rtl/cache_block_fetch.sv
// cache_block_fetch: miss-service engine. On a read request from the cache
// controller it fetches one whole block from main memory, one word per
// access with a fixed latency, assembles the words into block_data and then
// pulses done for one cycle.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   read        : fetch request, held by the controller until done
//   addr        : missing word address, sampled on accept
//   mem_rd      : one-cycle memory read strobe per word
//   mem_addr    : memory word address
//   mem_rdata   : memory data, valid exactly MEM_LAT cycles after mem_rd
//   block_data  : assembled block, word i at [i*WORD_W +: WORD_W]
//   done        : one-cycle pulse, block_data complete
//   busy        : high from accept through the done cycle
// Build option: CRITICAL_WORD_FIRST_EN starts the fetch at the requested
// word and wraps; otherwise words are fetched 0..BLK_WORDS-1.
module cache_block_fetch
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned BLK_WORDS = BLK_WORDS_DEF,
  parameter int unsigned MEM_LAT   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        read,
  input  logic [ADDR_W-1:0]           addr,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [WORD_W-1:0]           mem_rdata,
  output logic [BLK_WORDS*WORD_W-1:0] block_data,
  output logic                        done,
  output logic                        busy
);

  localparam int unsigned OFF_W  = off_w(BLK_WORDS);
  localparam int unsigned BASE_W = ADDR_W - OFF_W;
  localparam int unsigned TW     = $clog2(MEM_LAT) + 1;

  localparam logic [OFF_W-1:0] ONE      = OFF_W'(1);
  localparam logic [OFF_W-1:0] LAST     = OFF_W'(BLK_WORDS - 1);
  localparam logic [TW-1:0]    WAIT_LD  = TW'(MEM_LAT - 1);

  fetch_state_t      state;
  logic [BASE_W-1:0] base;
  logic [OFF_W-1:0]  idx;
  logic [OFF_W-1:0]  n;
  logic [OFF_W-1:0]  nxt_idx;
  logic [OFF_W-1:0]  start_off;
  logic              rearm;
  logic              tmr_load;
  logic              tmr_zero;

`ifdef CRITICAL_WORD_FIRST_EN
  always_comb begin
    start_off = addr[OFF_W-1:0];
  end
`else
  // Linear order: the requested word offset is deliberately discarded.
  always_comb begin
    start_off = addr[OFF_W-1:0] & '0;
  end
`endif

  // idx is OFF_W bits wide, so the increment wraps within the block.
  always_comb begin
    nxt_idx  = idx + ONE;
    tmr_load = (state == ISSUE);
  end

  mem_latency_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (WAIT_LD),
    .zero  (tmr_zero)
  );

  // Outputs are registered on state entry: mem_rd/mem_addr are set on the
  // edge that enters ISSUE, done on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      block_data <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      base       <= '0;
      idx        <= '0;
      n          <= '0;
      rearm      <= 1'b1;
    end else begin
      mem_rd <= 1'b0;
      done   <= 1'b0;
      if (!read) begin
        rearm <= 1'b1;
      end
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (read && rearm) begin
            base     <= addr[ADDR_W-1:OFF_W];
            idx      <= start_off;
            n        <= '0;
            busy     <= 1'b1;
            mem_rd   <= 1'b1;
            mem_addr <= {addr[ADDR_W-1:OFF_W], start_off};
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tmr_zero) begin
            for (int unsigned i = 0; i < BLK_WORDS; i++) begin
              if (idx == OFF_W'(i)) begin
                block_data[i*WORD_W +: WORD_W] <= mem_rdata;
              end
            end
            if (n == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx      <= nxt_idx;
              n        <= n + ONE;
              mem_rd   <= 1'b1;
              mem_addr <= {base, nxt_idx};
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          // A read still held after done must not restart the engine.
          rearm <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
